alarm_sequencer: RTL

Upstream controller for the 440 Hz tone generator. It turns a one-shot alarm trigger into a timed beep pattern on `buzzer_en`, which drives the tone generator's `en` input. The pattern is bursts of short beeps separated by a longer gap. It stops on user request, after a configurable number of bursts, or on reset.

---
 rtl/alarm_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alarm_sequencer.sv
// Alarm beep sequencer: turns a trigger edge into timed beep bursts.
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
module alarm_sequencer #(
    parameter int unsigned ON_CYC     = 10_000_000,
    parameter int unsigned OFF_CYC    = 10_000_000,
    parameter int unsigned GAP_CYC    = 50_000_000,
    parameter int unsigned BEEPS      = 3,
    parameter int unsigned MAX_BURSTS = 10,
    parameter int unsigned SNOOZE_CYC = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic       stop,
`ifdef ALARM_SNOOZE_EN
    input  logic       snooze,
`endif
    output logic       buzzer_en,
    output logic       active,
    output logic [7:0] burst_cnt,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP,
        S_SNOOZE
    } state_t;

    localparam logic [31:0] ON_LD   = 32'(ON_CYC - 1);
    localparam logic [31:0] OFF_LD  = 32'(OFF_CYC - 1);
    localparam logic [31:0] GAP_LD  = 32'(GAP_CYC - 1);
    localparam logic [31:0] LAST_BP = 32'(BEEPS - 1);
    localparam logic [31:0] LAST_BR = 32'(MAX_BURSTS - 1);
    localparam bit          FINITE  = (MAX_BURSTS != 0);

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] beep_idx;
    logic [31:0] burst_idx;
    logic        trig_q;
    logic        trig_edge;
    logic        expired;
    logic        pausable;

    assign trig_edge = trigger & ~trig_q;
    assign expired   = (cnt == 32'd0);
    assign pausable  = (state == S_ON) || (state == S_OFF) || (state == S_GAP);

`ifdef ALARM_SNOOZE_EN
    localparam logic [31:0] SNZ_LD = 32'(SNOOZE_CYC - 1);
    logic snooze_req;
    assign snooze_req = snooze & pausable;
`else
    logic snooze_req;
    logic unused_snooze;
    assign snooze_req    = 1'b0;
    assign unused_snooze = ^{32'(SNOOZE_CYC), pausable};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            beep_idx  <= '0;
            burst_idx <= '0;
            trig_q    <= 1'b0;
            buzzer_en <= 1'b0;
            active    <= 1'b0;
            burst_cnt <= '0;
            done      <= 1'b0;
        end else begin
            trig_q <= trigger;
            done   <= 1'b0;
            if (state != S_IDLE && stop) begin
                state     <= S_IDLE;
                cnt       <= '0;
                buzzer_en <= 1'b0;
                active    <= 1'b0;
            end else if (snooze_req) begin
`ifdef ALARM_SNOOZE_EN
                state     <= S_SNOOZE;
                cnt       <= SNZ_LD;
                buzzer_en <= 1'b0;
`endif
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (trig_edge) begin
                            state     <= S_ON;
                            cnt       <= ON_LD;
                            beep_idx  <= '0;
                            burst_idx <= '0;
                            burst_cnt <= '0;
                            buzzer_en <= 1'b1;
                            active    <= 1'b1;
                        end
                    end
                    S_ON: begin
                        if (!expired) begin
                            cnt <= cnt - 32'd1;
                        end else if (beep_idx < LAST_BP) begin
                            state     <= S_OFF;
                            cnt       <= OFF_LD;
                            buzzer_en <= 1'b0;
                        end else if (FINITE && burst_idx == LAST_BR) begin
                            // natural completion
                            state     <= S_IDLE;
                            buzzer_en <= 1'b0;
                            active    <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state     <= S_GAP;
                            cnt       <= GAP_LD;
                            buzzer_en <= 1'b0;
                        end
                    end
                    S_OFF: begin
                        if (!expired) begin
                            cnt <= cnt - 32'd1;
                        end else begin
                            state     <= S_ON;
                            cnt       <= ON_LD;
                            beep_idx  <= beep_idx + 32'd1;
                            buzzer_en <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (!expired) begin
                            cnt <= cnt - 32'd1;
                        end else begin
                            state     <= S_ON;
                            cnt       <= ON_LD;
                            beep_idx  <= '0;
                            burst_idx <= burst_idx + 32'd1;
                            buzzer_en <= 1'b1;
                            if (burst_cnt != 8'hFF)
                                burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                    S_SNOOZE: begin
                        if (!expired) begin
                            cnt <= cnt - 32'd1;
                        end else begin
                            state     <= S_ON;
                            cnt       <= ON_LD;
                            beep_idx  <= '0;
                            burst_idx <= '0;
                            burst_cnt <= '0;
                            buzzer_en <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        buzzer_en <= 1'b0;
                        active    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
